// File: rtl/exu_muldiv.sv
// rtl/exu_muldiv.sv - iterative RV32M multiply/divide unit with tagged valid/ready result
module exu_muldiv #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             muldiv_i_valid,
  output logic             muldiv_o_ready,
  input  logic [XLEN-1:0]  muldiv_i_a,
  input  logic [XLEN-1:0]  muldiv_i_b,
  input  logic [7:0]       muldiv_i_sel,
  input  logic [TAG_W-1:0] muldiv_i_tag,
  input  logic             muldiv_i_flush,
  output logic             muldiv_o_valid,
  input  logic             muldiv_i_ready,
  output logic [XLEN-1:0]  muldiv_o_out,
  output logic [TAG_W-1:0] muldiv_o_tag,
  output logic             muldiv_o_busy
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [2*XLEN-1:0] acc;      // multiply: {partial product, multiplier}; divide: {unused, dividend/quotient}
  logic [XLEN-1:0]   rem;      // divide: partial remainder (always < divisor)
  logic [XLEN-1:0]   opnd;     // multiplicand or divisor magnitude
  logic              op_div;
  logic              op_low;
  logic              op_rem;
  logic              neg_out;

  // Request decode: signedness, magnitudes and the one-cycle special cases
  logic            sel_onehot;
  logic            a_sgn, b_sgn, neg_a, neg_b;
  logic            req_div, req_rem, div_zero, div_ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  always_comb begin
    sel_onehot  = (muldiv_i_sel != 8'd0) && ((muldiv_i_sel & (muldiv_i_sel - 8'd1)) == 8'd0);
    a_sgn       = muldiv_i_sel[0] | muldiv_i_sel[1] | muldiv_i_sel[2] | muldiv_i_sel[4] | muldiv_i_sel[6];
    b_sgn       = muldiv_i_sel[0] | muldiv_i_sel[1] | muldiv_i_sel[4] | muldiv_i_sel[6];
    neg_a       = a_sgn & muldiv_i_a[XLEN-1];
    neg_b       = b_sgn & muldiv_i_b[XLEN-1];
    a_mag       = neg_a ? -muldiv_i_a : muldiv_i_a;
    b_mag       = neg_b ? -muldiv_i_b : muldiv_i_b;
    req_div     = muldiv_i_sel[4] | muldiv_i_sel[5] | muldiv_i_sel[6] | muldiv_i_sel[7];
    req_rem     = muldiv_i_sel[6] | muldiv_i_sel[7];
    div_zero    = req_div && (muldiv_i_b == '0);
    div_ovf     = (muldiv_i_sel[4] | muldiv_i_sel[6]) && (muldiv_i_a == MIN_INT) && (muldiv_i_b == '1);
    special     = !sel_onehot || div_zero || div_ovf;
    special_res = '0;
    if (!sel_onehot) begin
      special_res = '0;
    end else if (div_zero) begin
      special_res = req_rem ? muldiv_i_a : '1;
    end else if (div_ovf) begin
      special_res = req_rem ? '0 : MIN_INT;
    end
  end

  // One radix-2 step: shift-add for multiply, restoring trial subtract for divide
  logic [XLEN:0] mul_sum;
  logic [XLEN:0] div_shift;
  logic [XLEN:0] div_trial;

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = {rem, acc[XLEN-1]};
    div_trial = div_shift - {1'b0, opnd};
  end

  // Sign correction and result selection applied in FIX
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rmd, fix_res;

  always_comb begin
    prod    = neg_out ? -acc : acc;
    quo     = neg_out ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rmd     = neg_out ? -rem : rem;
    fix_res = op_div ? (op_rem ? rmd : quo)
                     : (op_low ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  end

  assign muldiv_o_ready = (state == S_IDLE);
  assign muldiv_o_busy  = (state != S_IDLE);

  // Control FSM and datapath registers; o_valid rises one cycle after entering DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      count          <= '0;
      acc            <= '0;
      rem            <= '0;
      opnd           <= '0;
      op_div         <= 1'b0;
      op_low         <= 1'b0;
      op_rem         <= 1'b0;
      neg_out        <= 1'b0;
      muldiv_o_valid <= 1'b0;
      muldiv_o_out   <= '0;
      muldiv_o_tag   <= '0;
    end else if (muldiv_i_flush) begin
      state          <= S_IDLE;
      muldiv_o_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (muldiv_i_valid) begin
            muldiv_o_tag <= muldiv_i_tag;
            op_div       <= req_div;
            op_rem       <= req_rem;
            op_low       <= muldiv_i_sel[0];
            neg_out      <= req_rem ? neg_a : (neg_a ^ neg_b);
            rem          <= '0;
            if (special) begin
              muldiv_o_out <= special_res;
              state        <= S_DONE;
            end else begin
              acc   <= {{XLEN{1'b0}}, req_div ? a_mag : b_mag};
              opnd  <= req_div ? b_mag : a_mag;
              count <= CNT_W'(XLEN);
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (op_div) begin
            if (!div_trial[XLEN]) begin
              rem <= div_trial[XLEN-1:0];
              acc <= {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], 1'b1};
            end else begin
              rem <= div_shift[XLEN-1:0];
              acc <= {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], 1'b0};
            end
          end else begin
            acc <= {mul_sum, acc[XLEN-1:1]};
          end
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          muldiv_o_out <= fix_res;
          state        <= S_DONE;
        end
        S_DONE: begin
          if (!muldiv_o_valid) begin
            muldiv_o_valid <= 1'b1;
          end else if (muldiv_i_ready) begin
            muldiv_o_valid <= 1'b0;
            state          <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exu_muldiv.sv
// tb/tb_exu_muldiv.sv - self-checking bench for exu_muldiv against an arithmetic reference model
module tb_exu_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic [7:0]  i_sel;
  logic [4:0]  i_tag;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_out;
  logic [4:0]  o_tag;
  logic        o_busy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  exu_muldiv #(.XLEN(32), .TAG_W(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .muldiv_i_valid (i_valid),
    .muldiv_o_ready (o_ready),
    .muldiv_i_a     (i_a),
    .muldiv_i_b     (i_b),
    .muldiv_i_sel   (i_sel),
    .muldiv_i_tag   (i_tag),
    .muldiv_i_flush (i_flush),
    .muldiv_o_valid (o_valid),
    .muldiv_i_ready (i_ready),
    .muldiv_o_out   (o_out),
    .muldiv_o_tag   (o_tag),
    .muldiv_o_busy  (o_busy)
  );

  // Reference result from 64-bit signed/unsigned arithmetic
  function automatic logic [31:0] model(input logic [7:0] sel, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (sel)
      8'h01: begin p = sa * sb; return p[31:0]; end
      8'h02: begin p = sa * sb; return p[63:32]; end
      8'h04: begin p = sa * ub; return p[63:32]; end
      8'h08: begin p = ua * ub; return p[63:32]; end
      8'h10: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      8'h20: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      8'h40: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      8'h80: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [7:0] sel, input logic [31:0] a, input logic [31:0] b);
    bit onehot;
    onehot = (sel == 8'h01) || (sel == 8'h02) || (sel == 8'h04) || (sel == 8'h08) ||
             (sel == 8'h10) || (sel == 8'h20) || (sel == 8'h40) || (sel == 8'h80);
    if (!onehot) return 1;
    if ((sel >= 8'h10) && (b == 0)) return 1;
    if (((sel == 8'h10) || (sel == 8'h40)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
    return 34;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issue one request, wait for its result, optionally stall the consumer, then retire it
  task automatic run_op(input string name, input logic [7:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] exp, input int lat, input int hold);
    int cyc;
    @(negedge clk);
    chk({name, "/ready_before"}, 64'(o_ready), 64'd1);
    i_valid = 1'b1; i_a = a; i_b = b; i_sel = sel; i_tag = tag;
    @(posedge clk); #1;
    i_valid = 1'b0; i_a = $urandom; i_b = $urandom; i_sel = 8'($urandom); i_tag = 5'($urandom);
    chk({name, "/busy_after_accept"}, {62'd0, o_ready, o_busy}, 64'd1);
    cyc = 0;
    while (!o_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({name, "/latency"}, 64'(cyc), 64'(lat));
    chk({name, "/out"}, 64'(o_out), 64'(exp));
    chk({name, "/tag"}, 64'(o_tag), 64'(tag));
    repeat (hold) begin
      @(posedge clk); #1;
      chk({name, "/hold"}, {25'd0, o_valid, o_ready, o_tag, o_out}, {25'd0, 1'b1, 1'b0, tag, exp});
    end
    @(negedge clk);
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    chk({name, "/retire"}, {61'd0, o_valid, o_ready, o_busy}, 64'b010);
  endtask

  task automatic watch_no_valid(input string name, input int cycles);
    bit seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #1;
      seen |= o_valid;
    end
    chk(name, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [7:0]  r_sel;
    logic [31:0] r_a, r_b;
    logic [4:0]  r_tag;
    int          pick;

    rst_n = 1'b0; i_valid = 1'b0; i_a = '0; i_b = '0; i_sel = '0; i_tag = '0;
    i_flush = 1'b0; i_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {24'd0, o_valid, o_ready, o_busy, o_tag, o_out}, {24'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0});
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mul_7_m3",   8'h01, 32'd7,          32'hFFFF_FFFD, 5'd9,  32'hFFFF_FFEB, 34, 0);
    run_op("mulh_min",   8'h02, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000, 34, 0);
    run_op("mulhu_min",  8'h08, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000, 34, 0);
    run_op("mulhsu_m1",  8'h04, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 34, 0);
    run_op("div_m7_2",   8'h10, 32'hFFFF_FFF9, 32'd2,          5'd4,  32'hFFFF_FFFD, 34, 0);
    run_op("rem_m7_2",   8'h40, 32'hFFFF_FFF9, 32'd2,          5'd5,  32'hFFFF_FFFF, 34, 0);
    run_op("divu_100_7", 8'h20, 32'd100,        32'd7,          5'd6,  32'd14,        34, 0);
    run_op("remu_100_7", 8'h80, 32'd100,        32'd7,          5'd7,  32'd2,         34, 0);
    run_op("divu_by0",   8'h20, 32'd5,          32'd0,          5'd8,  32'hFFFF_FFFF, 1,  0);
    run_op("rem_ovf",    8'h40, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0,         1,  0);
    run_op("div_ovf",    8'h10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1,  0);
    run_op("rem_by0",    8'h40, 32'hDEAD_BEEF, 32'd0,          5'd12, 32'hDEAD_BEEF, 1,  0);
    run_op("sel_zero",   8'h00, 32'd3,          32'd4,          5'd13, 32'd0,         1,  0);
    run_op("sel_multi",  8'h03, 32'd3,          32'd4,          5'd14, 32'd0,         1,  0);

    run_op("stall_10",   8'h01, 32'd1234,       32'd5678,       5'd21, 32'd7006652,   34, 10);
    run_op("after_stall", 8'h20, 32'd99,        32'd10,         5'd22, 32'd9,         34, 0);

    // Flush at iteration 12 of a DIV: result must never appear
    @(negedge clk);
    i_valid = 1'b1; i_a = 32'd1000; i_b = 32'd3; i_sel = 8'h10; i_tag = 5'd17;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    chk("flush_calc/idle", {61'd0, o_valid, o_ready, o_busy}, 64'b010);
    watch_no_valid("flush_calc/no_valid", 40);

    // Reset at iteration 20 of a MUL
    @(negedge clk);
    i_valid = 1'b1; i_a = 32'd77; i_b = 32'd88; i_sel = 8'h01; i_tag = 5'd18;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_mid/state", {24'd0, o_valid, o_ready, o_busy, o_tag, o_out}, {24'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0});
    @(negedge clk);
    rst_n = 1'b1;
    watch_no_valid("reset_mid/no_valid", 40);
    run_op("mul_3_4", 8'h01, 32'd3, 32'd4, 5'd19, 32'd12, 34, 0);

    // Flush together with a request blocks the accept
    @(negedge clk);
    i_valid = 1'b1; i_flush = 1'b1; i_a = 32'd6; i_b = 32'd7; i_sel = 8'h01;
    @(posedge clk); #1;
    i_valid = 1'b0; i_flush = 1'b0;
    chk("flush_valid/not_accepted", {62'd0, o_ready, o_busy}, 64'b10);

    // Flush in DONE without ready drops the held result
    @(negedge clk);
    i_valid = 1'b1; i_a = 32'd5; i_b = 32'd0; i_sel = 8'h20; i_tag = 5'd23;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    chk("flush_done/valid_up", 64'(o_valid), 64'd1);
    @(negedge clk);
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    chk("flush_done/dropped", {62'd0, o_valid, o_ready}, 64'b01);

    // Flush with ready in DONE still completes the handshake, then idles
    @(negedge clk);
    i_valid = 1'b1; i_a = 32'd5; i_b = 32'd0; i_sel = 8'h80; i_tag = 5'd24;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    chk("flush_ready/result", {26'd0, o_valid, o_tag, o_out}, {26'd0, 1'b1, 5'd24, 32'd5});
    @(negedge clk);
    i_flush = 1'b1; i_ready = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0; i_ready = 1'b0;
    chk("flush_ready/idle", {61'd0, o_valid, o_ready, o_busy}, 64'b010);

    // Randomized ops against the reference model
    for (int k = 0; k < 30; k++) begin
      pick  = $urandom_range(0, 9);
      r_sel = (pick < 8) ? (8'd1 << pick) : ((pick == 8) ? 8'($urandom) : 8'd0);
      r_a   = $urandom;
      r_b   = $urandom;
      if ($urandom_range(0, 7) == 0) r_b = 32'd0;
      if ($urandom_range(0, 9) == 0) begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
      if ($urandom_range(0, 3) == 0) r_b = r_b >> $urandom_range(1, 28);
      r_tag = 5'($urandom);
      run_op($sformatf("rand%0d_sel%02h", k, r_sel), r_sel, r_a, r_b, r_tag,
             model(r_sel, r_a, r_b), model_lat(r_sel, r_a, r_b), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
